data_array_nway: RTL and testbench
==================================

# data_array_nway

Parametrised, multi-way successor to the cache line store. Holds `num_ways` × `num_sets` lines with per-byte write enables into one selected way, and a registered one-cycle read returning all ways of a set. A built-in sweep FSM zeroes the array after reset or on a `clear` request, so the storage itself needs no reset and maps to block RAM. It sits under the cache controller beside the tag/valid arrays, which tolerate the same one-cycle read latency.

## Interface
- `s_offset`, default 5: log2 bytes per line; `s_mask = 2**s_offset`, `s_line = 8*s_mask`.
- `s_index`, default 3: log2 sets; `num_sets = 2**s_index`.
- `num_ways`, default 2: ways, ≥1; `s_way = max(1, $clog2(num_ways))`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  request a full re-zero sweep.
- `ready`  out  1  array accepts reads/writes.
- `read`  in  1  read request, sampled when `ready`.
- `rindex`  in  `s_index`  read set.
- `write_en`  in  `s_mask`  byte write enables, bit i → byte i of the line.
- `wway`  in  `s_way`  way to write.
- `windex`  in  `s_index`  write set.
- `datain`  in  `s_line`  write data.
- `dataout`  out  `num_ways*s_line`  way w at `[w*s_line +: s_line]`.
- `dataout_valid`  out  1  `dataout` updated by a read this cycle.

## Operation
- States: INIT and IDLE. A `s_index`-bit sweep counter `cnt` is used only in INIT.
- Reset (async, any time, including mid-sweep or mid-read): state=INIT, `cnt`=0, `ready`=0, `dataout_valid`=0, `dataout`=0. Array contents are not reset.
- INIT: each edge writes zero to all ways of set `cnt`, then increments `cnt`. The edge that clears set `num_sets-1` moves to IDLE and sets `ready`=1.
  - `read` and `write_en` are ignored in INIT.
  - `clear` asserted in INIT restarts with `cnt`=0.
- IDLE with `clear`=1: go to INIT, `cnt`=0, `ready`=0, `dataout`=0. Any `read`/`write_en` in that cycle is dropped; `clear` has priority.
- Write (IDLE, no `clear`): for each i with `write_en[i]`, byte i of line [`wway`][`windex`] takes `datain[8*i +: 8]`. Other bytes and ways are unchanged.
  - `wway` ≥ `num_ways` means no write.
  - `write_en`=0 means no write.
- Read (IDLE, `read`=1, no `clear`): at the edge, `dataout` loads all ways of set `rindex` and `dataout_valid`=1 for the following cycle only. Without an accepted read, `dataout` holds its last value and `dataout_valid`=0.
- Read and write in the same cycle with `rindex`==`windex` is write-first. The returned way `wway` equals the old line merged with the enabled `datain` bytes. Other ways return old contents. Different indices do not interact.

## Timing
- Read latency 1: request at edge N is visible on `dataout`/`dataout_valid` after edge N. Reads may issue back-to-back every cycle.
- Write latency 1: a read issued the cycle after a write returns the written data.
- INIT takes exactly `num_sets` cycles: `rst` deasserts, and `ready` rises after the `num_sets`-th rising edge.
- `ready` is registered, never combinational from inputs. Upstream may hold `read`/`write_en` while `ready`=0; they are ignored, not queued.
- All outputs are registered; no combinational input→output paths.

## Test plan
Defaults throughout: 8 sets, 32-byte lines, 2 ways.

- Reset/sweep: pulse `rst`; hold `read`=1. Required: `ready`=0 and `dataout_valid`=0 for 8 cycles, `ready`=1 on cycle 9. A read of every set/way then returns all-zero, including after pre-reset writes of 0xFF…FF.
- Byte-masked write: write way 1, set 5, `write_en`=0x0000_000F, `datain`=all 0xAB bytes; next read of set 5. Required: way 1 bytes 0–3 = 0xAB, bytes 4–31 = 0, way 0 all 0.
- Write-first bypass: set 3 way 0 preloaded with 0x11 bytes; in the same cycle, write `write_en`=0x1 with byte 0xEE and read set 3. Required: next cycle way 0 byte 0 = 0xEE, bytes 1–31 = 0x11, `dataout_valid`=1 for one cycle.
- Clear priority: in IDLE assert `clear`, `read`, and a full write to set 2 simultaneously. Required:
  - `ready` drops next cycle, `dataout`=0, no `dataout_valid`;
  - after 8 cycles, set 2 reads zero.
- Clear restart: assert `clear` again 4 cycles into a sweep. Required: `ready` rises 8 cycles after the second `clear`, not the first.
- Async reset mid-read: assert `rst` between edges during back-to-back reads. Required: `dataout_valid`, `ready`, and `dataout` go 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/data_array_nway.sv
// rtl/data_array_nway.sv - multi-way cache line store with byte-masked writes and a zeroing sweep
module data_array_nway #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 2,
  localparam int s_mask   = 2 ** s_offset,
  localparam int s_line   = 8 * s_mask,
  localparam int num_sets = 2 ** s_index,
  localparam int s_way    = (num_ways > 1) ? $clog2(num_ways) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  output logic                         ready,
  input  logic                         read,
  input  logic [s_index-1:0]           rindex,
  input  logic [s_mask-1:0]            write_en,
  input  logic [s_way-1:0]             wway,
  input  logic [s_index-1:0]           windex,
  input  logic [s_line-1:0]            datain,
  output logic [num_ways*s_line-1:0]   dataout,
  output logic                         dataout_valid
);

  typedef enum logic {INIT, IDLE} state_t;

  state_t               state_q, state_d;
  logic [s_index-1:0]   cnt_q, cnt_d;
  logic                 ready_d;
  logic                 dout_clr;
  logic                 sweep;
  logic                 wr_en;
  logic                 rd_acc;
  logic [num_ways*s_line-1:0] rd_all;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    dout_clr = 1'b0;
    sweep    = 1'b0;
    wr_en    = 1'b0;
    rd_acc   = 1'b0;
    case (state_q)
      INIT: begin
        if (clear) begin
          cnt_d = '0;
        end else begin
          sweep = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_d = IDLE;
            ready_d = 1'b1;
          end
        end
      end
      IDLE: begin
        if (clear) begin
          state_d  = INIT;
          cnt_d    = '0;
          dout_clr = 1'b1;
        end else begin
          ready_d = 1'b1;
          wr_en   = (|write_en) && (int'(wway) < num_ways);
          rd_acc  = read;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= INIT;
      cnt_q         <= '0;
      ready         <= 1'b0;
      dataout_valid <= 1'b0;
      dataout       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ready         <= ready_d;
      dataout_valid <= rd_acc;
      if (dout_clr)
        dataout <= '0;
      else if (rd_acc)
        dataout <= rd_all;
    end
  end

  // Storage has no reset so it can map to block RAM; the sweep zeroes it instead.
  for (genvar w = 0; w < num_ways; w++) begin : g_way
    logic [s_line-1:0] mem [num_sets];
    logic [s_line-1:0] merged;
    logic              sel;

    assign sel = wr_en && (wway == s_way'(w));

    always_ff @(posedge clk) begin
      if (sweep) begin
        mem[cnt_q] <= '0;
      end else if (sel) begin
        for (int i = 0; i < s_mask; i++)
          if (write_en[i])
            mem[windex][8*i +: 8] <= datain[8*i +: 8];
      end
    end

    // Write-first: a same-set write in the read cycle is merged into the returned line.
    always_comb begin
      merged = mem[rindex];
      if (sel && (windex == rindex)) begin
        for (int i = 0; i < s_mask; i++)
          if (write_en[i])
            merged[8*i +: 8] = datain[8*i +: 8];
      end
    end

    assign rd_all[w*s_line +: s_line] = merged;
  end

endmodule

// File: tb/tb_data_array_nway.sv
// tb/tb_data_array_nway.sv - directed self-checking bench for data_array_nway
module tb_data_array_nway;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         ready;
  logic         read;
  logic [2:0]   rindex;
  logic [31:0]  write_en;
  logic [0:0]   wway;
  logic [2:0]   windex;
  logic [255:0] datain;
  logic [511:0] dataout;
  logic         dataout_valid;

  int n_assert = 0;
  int n_fail   = 0;

  logic [255:0] l_ab, l_11, l_ff, l_5a, l_bypass;

  data_array_nway dut (
    .clk(clk), .rst(rst), .clear(clear), .ready(ready), .read(read),
    .rindex(rindex), .write_en(write_en), .wway(wway), .windex(windex),
    .datain(datain), .dataout(dataout), .dataout_valid(dataout_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    l_ab     = {224'h0, 32'hABABABAB};
    l_11     = {32{8'h11}};
    l_ff     = {32{8'hFF}};
    l_5a     = {32{8'h5A}};
    l_bypass = {{31{8'h11}}, 8'hEE};

    rst = 1'b1; clear = 1'b0; read = 1'b1; rindex = 3'd0;
    write_en = '0; wway = '0; windex = '0; datain = '0;
    step(); step();
    check("reset_ready", 512'(ready), 512'(0));
    check("reset_valid", 512'(dataout_valid), 512'(0));
    check("reset_dataout", dataout, 512'h0);

    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("sweep_ready_%0d", k), 512'(ready), 512'(k == 8));
      check($sformatf("sweep_valid_%0d", k), 512'(dataout_valid), 512'(0));
    end
    step();
    check("first_read_valid", 512'(dataout_valid), 512'(1));
    check("first_read_zero", dataout, 512'h0);

    // Fill everything with ones, then reset asynchronously between edges.
    read = 1'b0; write_en = '1; datain = l_ff;
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 2; w++) begin
        windex = 3'(s); wway = 1'(w);
        step();
      end
    write_en = '0;
    rst = 1'b1; #2; rst = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    check("resweep_ready", 512'(ready), 512'(1));
    read = 1'b1;
    for (int s = 0; s < 8; s++) begin
      rindex = 3'(s);
      step();
      check($sformatf("zero_set_%0d", s), dataout, 512'h0);
      check($sformatf("zero_valid_%0d", s), 512'(dataout_valid), 512'(1));
    end
    read = 1'b0;

    // Byte-masked write into way 1, set 5.
    write_en = 32'h0000_000F; wway = 1'b1; windex = 3'd5; datain = {32{8'hAB}};
    step();
    write_en = '0; read = 1'b1; rindex = 3'd5;
    step();
    read = 1'b0;
    check("mask_data", dataout, {l_ab, 256'h0});
    check("mask_valid", 512'(dataout_valid), 512'(1));
    step();
    check("mask_valid_drop", 512'(dataout_valid), 512'(0));
    check("mask_hold", dataout, {l_ab, 256'h0});

    // Write-first bypass on set 3 way 0.
    write_en = '1; wway = 1'b0; windex = 3'd3; datain = l_11;
    step();
    write_en = 32'h1; datain = {32{8'hEE}}; read = 1'b1; rindex = 3'd3;
    step();
    write_en = '0; read = 1'b0;
    check("bypass_data", dataout, {256'h0, l_bypass});
    check("bypass_valid", 512'(dataout_valid), 512'(1));
    step();
    check("bypass_valid_drop", 512'(dataout_valid), 512'(0));
    read = 1'b1;
    step();
    read = 1'b0;
    check("bypass_stored", dataout, {256'h0, l_bypass});

    // Clear beats a simultaneous read and write.
    clear = 1'b1; read = 1'b1; rindex = 3'd5;
    write_en = '1; wway = 1'b0; windex = 3'd2; datain = l_ff;
    step();
    clear = 1'b0; read = 1'b0; write_en = '0;
    check("clear_ready", 512'(ready), 512'(0));
    check("clear_dataout", dataout, 512'h0);
    check("clear_valid", 512'(dataout_valid), 512'(0));
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("clear_sweep_ready_%0d", k), 512'(ready), 512'(k == 8));
    end
    read = 1'b1; rindex = 3'd2;
    step();
    check("clear_set2", dataout, 512'h0);
    rindex = 3'd5;
    step();
    read = 1'b0;
    check("clear_set5", dataout, 512'h0);
    check("clear_set5_valid", 512'(dataout_valid), 512'(1));

    // Clear restarts a sweep already in progress.
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("restart_ready_%0d", k), 512'(ready), 512'(k == 8));
    end

    // Async reset during back-to-back reads.
    write_en = '1; wway = 1'b0; windex = 3'd1; datain = l_5a;
    step();
    write_en = '0; read = 1'b1; rindex = 3'd1;
    step();
    check("b2b_data_1", dataout, {256'h0, l_5a});
    check("b2b_valid_1", 512'(dataout_valid), 512'(1));
    step();
    check("b2b_valid_2", 512'(dataout_valid), 512'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_ready", 512'(ready), 512'(0));
    check("async_valid", 512'(dataout_valid), 512'(0));
    check("async_dataout", dataout, 512'h0);
    #1;
    rst = 1'b0; read = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    check("final_ready", 512'(ready), 512'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
